// File: rtl/poly_arith_pkg.sv
// Shared types for the polynomial arithmetic datapath.
// Coefficient type, PE mode encoding and write-back widths.
package poly_arith_pkg;

   localparam int COEFF_W = 12;

   typedef logic [COEFF_W-1:0] coeff_t;

   typedef enum logic [1:0] {
      PE_MODE_NTT  = 2'd0,
      PE_MODE_INTT = 2'd1,
      PE_MODE_CWM  = 2'd2,
      PE_MODE_MUL  = 2'd3
   } pe_mode_e;

   localparam int PE2_WB_DATA_W = 24;

endpackage

// File: rtl/pe2_wb_collector_tag_fifo.sv
// In-order tag FIFO holding write addresses for results still inside PE2.
// Power-of-2 depth, wrapping pointers, async reset and sync clear.
module tag_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push at full is legal then.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/pe2_wb_collector.sv
// Pairs untagged PE2 results with issue-time write addresses
// and drives the coefficient-memory u/v and m write ports.
module pe2_wb_collector
   import poly_arith_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int TAG_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear_i,
   input  logic                     issue_valid_i,
   input  pe_mode_e                 issue_mode_i,
   input  logic [ADDR_W-1:0]        issue_addr_i,
   input  logic [ADDR_W-1:0]        issue_m_addr_i,
   output logic                     tag_full_o,
   input  coeff_t                   u2_i,
   input  coeff_t                   v2_i,
   input  logic                     valid_i,
   input  coeff_t                   m_i,
   input  logic                     valid_m_i,
   output logic                     wr_en_o,
   output logic [ADDR_W-1:0]        wr_addr_o,
   output logic [PE2_WB_DATA_W-1:0] wr_data_o,
   output logic                     wr_m_en_o,
   output logic [ADDR_W-1:0]        wr_m_addr_o,
   output coeff_t                   wr_m_data_o,
   output logic                     idle_o,
   output logic                     err_ovf_o,
   output logic                     err_orphan_o
);

   localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

   logic              uv_full, uv_empty, m_full, m_empty;
   logic [CNT_W-1:0]  uv_count, m_count;
   logic [ADDR_W-1:0] uv_head, m_head;
   logic              is_cwm;
   logic              uv_pop, m_pop;
   logic              uv_block, m_block;
   logic              reject, accept;
   logic              uv_push, m_push;
   logic              orphan;

   assign is_cwm = (issue_mode_i == PE_MODE_CWM);

   // No bypass: results only match tags already stored.
   assign uv_pop = valid_i && !uv_empty;
   assign m_pop  = valid_m_i && !m_empty;

   assign uv_block = uv_full && !uv_pop;
   assign m_block  = is_cwm && m_full && !m_pop;
   assign reject   = issue_valid_i && (uv_block || m_block);
   assign accept   = issue_valid_i && !reject;
   assign uv_push  = accept;
   assign m_push   = accept && is_cwm;

   assign orphan = (valid_i && uv_empty) || (valid_m_i && m_empty);

   tag_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (TAG_DEPTH)
   ) u_uv_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_i),
      .push  (uv_push),
      .din   (issue_addr_i),
      .pop   (uv_pop),
      .dout  (uv_head),
      .full  (uv_full),
      .empty (uv_empty),
      .count (uv_count)
   );

   tag_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (TAG_DEPTH)
   ) u_m_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (clear_i),
      .push  (m_push),
      .din   (issue_m_addr_i),
      .pop   (m_pop),
      .dout  (m_head),
      .full  (m_full),
      .empty (m_empty),
      .count (m_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         wr_m_en_o    <= 1'b0;
         wr_m_addr_o  <= '0;
         wr_m_data_o  <= '0;
         err_ovf_o    <= 1'b0;
         err_orphan_o <= 1'b0;
      end else if (clear_i) begin
         wr_en_o      <= 1'b0;
         wr_addr_o    <= '0;
         wr_data_o    <= '0;
         wr_m_en_o    <= 1'b0;
         wr_m_addr_o  <= '0;
         wr_m_data_o  <= '0;
         err_ovf_o    <= 1'b0;
         err_orphan_o <= 1'b0;
      end else begin
         wr_en_o   <= uv_pop;
         wr_m_en_o <= m_pop;
         if (uv_pop) begin
            wr_addr_o <= uv_head;
            wr_data_o <= {v2_i, u2_i};
         end
         if (m_pop) begin
            wr_m_addr_o <= m_head;
            wr_m_data_o <= m_i;
         end
         err_ovf_o    <= err_ovf_o | reject;
         err_orphan_o <= err_orphan_o | orphan;
      end
   end

   // Conservative: an NTT beat also stalls on a full m FIFO.
   assign tag_full_o = uv_full || m_full;

   assign idle_o = (uv_count == '0) && (m_count == '0)
                && !wr_en_o && !wr_m_en_o;

endmodule

// File: tb/tb_pe2_wb_collector.sv
// Directed bench for pe2_wb_collector: vector table for streams,
// hand sequences for full, orphan, clear and reset corners.
module tb_pe2_wb_collector;
   import poly_arith_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        issue_valid = 1'b0;
   pe_mode_e    issue_mode = PE_MODE_NTT;
   logic [7:0]  issue_addr = '0;
   logic [7:0]  issue_m_addr = '0;
   logic        tag_full;
   coeff_t      u2 = '0;
   coeff_t      v2 = '0;
   logic        valid = 1'b0;
   coeff_t      m = '0;
   logic        valid_m = 1'b0;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [23:0] wr_data;
   logic        wr_m_en;
   logic [7:0]  wr_m_addr;
   coeff_t      wr_m_data;
   logic        idle;
   logic        err_ovf;
   logic        err_orphan;

   int checks = 0;
   int errors = 0;

   pe2_wb_collector #(.ADDR_W(8), .TAG_DEPTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .clear_i        (clear),
      .issue_valid_i  (issue_valid),
      .issue_mode_i   (issue_mode),
      .issue_addr_i   (issue_addr),
      .issue_m_addr_i (issue_m_addr),
      .tag_full_o     (tag_full),
      .u2_i           (u2),
      .v2_i           (v2),
      .valid_i        (valid),
      .m_i            (m),
      .valid_m_i      (valid_m),
      .wr_en_o        (wr_en),
      .wr_addr_o      (wr_addr),
      .wr_data_o      (wr_data),
      .wr_m_en_o      (wr_m_en),
      .wr_m_addr_o    (wr_m_addr),
      .wr_m_data_o    (wr_m_data),
      .idle_o         (idle),
      .err_ovf_o      (err_ovf),
      .err_orphan_o   (err_orphan)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       iv;
      pe_mode_e   md;
      logic [7:0] a;
      logic [7:0] ma;
      logic       v;
      coeff_t     u;
      coeff_t     vv;
      logic       vm;
      coeff_t     mm;
      logic       we;
      logic [7:0] wa;
      logic [23:0] wd;
      logic       mwe;
      logic [7:0] mwa;
      coeff_t     mwd;
      logic       idl;
   } vec_t;

   vec_t tbl [15];

   function automatic vec_t mkv(
      input logic iv, input pe_mode_e md,
      input logic [7:0] a, input logic [7:0] ma,
      input logic v, input coeff_t u, input coeff_t vv,
      input logic vm, input coeff_t mm,
      input logic we, input logic [7:0] wa, input logic [23:0] wd,
      input logic mwe, input logic [7:0] mwa, input coeff_t mwd,
      input logic idl);
      vec_t r;
      r.iv = iv;  r.md = md;   r.a = a;    r.ma = ma;
      r.v = v;    r.u = u;     r.vv = vv;
      r.vm = vm;  r.mm = mm;
      r.we = we;  r.wa = wa;   r.wd = wd;
      r.mwe = mwe; r.mwa = mwa; r.mwd = mwd;
      r.idl = idl;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic quiet();
      issue_valid = 1'b0;
      valid = 1'b0;
      valid_m = 1'b0;
      clear = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic iss(input logic [7:0] a, input logic [7:0] ma,
                      input pe_mode_e md);
      issue_valid = 1'b1;
      issue_addr = a;
      issue_m_addr = ma;
      issue_mode = md;
   endtask

   initial begin
      // NTT stream: results 0x10..0x13 one cycle after valid_i
      tbl[0]  = mkv(1, PE_MODE_NTT, 8'h10, 8'h00, 0, 12'h000, 12'h000, 0, 12'h000,
                    0, 8'h00, 24'h000000, 0, 8'h00, 12'h000, 0);
      tbl[1]  = mkv(1, PE_MODE_NTT, 8'h11, 8'h00, 0, 12'h000, 12'h000, 0, 12'h000,
                    0, 8'h00, 24'h000000, 0, 8'h00, 12'h000, 0);
      tbl[2]  = mkv(1, PE_MODE_NTT, 8'h12, 8'h00, 1, 12'h101, 12'h201, 0, 12'h000,
                    1, 8'h10, 24'h201101, 0, 8'h00, 12'h000, 0);
      tbl[3]  = mkv(1, PE_MODE_NTT, 8'h13, 8'h00, 1, 12'h102, 12'h202, 0, 12'h000,
                    1, 8'h11, 24'h202102, 0, 8'h00, 12'h000, 0);
      tbl[4]  = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 1, 12'h103, 12'h203, 0, 12'h000,
                    1, 8'h12, 24'h203103, 0, 8'h00, 12'h000, 0);
      tbl[5]  = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 1, 12'h104, 12'h204, 0, 12'h000,
                    1, 8'h13, 24'h204104, 0, 8'h00, 12'h000, 0);
      tbl[6]  = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 12'h000,
                    0, 8'h13, 24'h204104, 0, 8'h00, 12'h000, 1);
      // CWM stream: m results trail the u/v results
      tbl[7]  = mkv(1, PE_MODE_CWM, 8'h20, 8'h80, 0, 12'h000, 12'h000, 0, 12'h000,
                    0, 8'h13, 24'h204104, 0, 8'h00, 12'h000, 0);
      tbl[8]  = mkv(1, PE_MODE_CWM, 8'h21, 8'h81, 1, 12'h111, 12'h211, 0, 12'h000,
                    1, 8'h20, 24'h211111, 0, 8'h00, 12'h000, 0);
      tbl[9]  = mkv(1, PE_MODE_CWM, 8'h22, 8'h82, 1, 12'h112, 12'h212, 0, 12'h000,
                    1, 8'h21, 24'h212112, 0, 8'h00, 12'h000, 0);
      tbl[10] = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 1, 12'h113, 12'h213, 0, 12'h000,
                    1, 8'h22, 24'h213113, 0, 8'h00, 12'h000, 0);
      tbl[11] = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 12'h301,
                    0, 8'h22, 24'h213113, 1, 8'h80, 12'h301, 0);
      tbl[12] = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 12'h302,
                    0, 8'h22, 24'h213113, 1, 8'h81, 12'h302, 0);
      tbl[13] = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 0, 12'h000, 12'h000, 1, 12'h303,
                    0, 8'h22, 24'h213113, 1, 8'h82, 12'h303, 0);
      tbl[14] = mkv(0, PE_MODE_NTT, 8'h00, 8'h00, 0, 12'h000, 12'h000, 0, 12'h000,
                    0, 8'h22, 24'h213113, 0, 8'h82, 12'h303, 1);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_wr_en", 32'(wr_en), 32'd0);
      chk("rst_wr_m_en", 32'(wr_m_en), 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_tag_full", 32'(tag_full), 32'd0);
      chk("rst_errs", 32'({err_ovf, err_orphan}), 32'd0);
      chk("rst_wr_data", 32'(wr_data), 32'd0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 15; i++) begin
         issue_valid  = tbl[i].iv;
         issue_mode   = tbl[i].md;
         issue_addr   = tbl[i].a;
         issue_m_addr = tbl[i].ma;
         valid        = tbl[i].v;
         u2           = tbl[i].u;
         v2           = tbl[i].vv;
         valid_m      = tbl[i].vm;
         m            = tbl[i].mm;
         tick();
         chk($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].we));
         chk($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
         chk($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(tbl[i].wd));
         chk($sformatf("v%0d_wr_m_en", i), 32'(wr_m_en), 32'(tbl[i].mwe));
         chk($sformatf("v%0d_wr_m_addr", i), 32'(wr_m_addr), 32'(tbl[i].mwa));
         chk($sformatf("v%0d_wr_m_data", i), 32'(wr_m_data), 32'(tbl[i].mwd));
         chk($sformatf("v%0d_idle", i), 32'(idle), 32'(tbl[i].idl));
         chk($sformatf("v%0d_tag_full", i), 32'(tag_full), 32'd0);
         chk($sformatf("v%0d_errs", i), 32'({err_ovf, err_orphan}), 32'd0);
      end
      quiet();

      // Fill to TAG_DEPTH
      for (int i = 0; i < 8; i++) begin
         iss(8'h40 + 8'(i), 8'h00, PE_MODE_NTT);
         tick();
      end
      quiet();
      chk("fill_tag_full", 32'(tag_full), 32'd1);
      chk("fill_ovf", 32'(err_ovf), 32'd0);
      chk("fill_idle", 32'(idle), 32'd0);

      // Push and pop together at full
      iss(8'h48, 8'h00, PE_MODE_NTT);
      valid = 1'b1; u2 = 12'h0AA; v2 = 12'h0BB;
      tick();
      quiet();
      chk("pp_ovf", 32'(err_ovf), 32'd0);
      chk("pp_wr_en", 32'(wr_en), 32'd1);
      chk("pp_wr_addr", 32'(wr_addr), 32'h40);
      chk("pp_wr_data", 32'(wr_data), 32'h0BB0AA);
      chk("pp_tag_full", 32'(tag_full), 32'd1);

      // Ninth beat without a pop is dropped
      iss(8'h49, 8'h00, PE_MODE_NTT);
      tick();
      quiet();
      chk("ovf_set", 32'(err_ovf), 32'd1);
      chk("ovf_tag_full", 32'(tag_full), 32'd1);
      chk("ovf_wr_en", 32'(wr_en), 32'd0);

      for (int i = 0; i < 8; i++) begin
         valid = 1'b1;
         u2 = 12'(i);
         v2 = 12'h000;
         tick();
         chk($sformatf("drain%0d_wr_en", i), 32'(wr_en), 32'd1);
         chk($sformatf("drain%0d_addr", i), 32'(wr_addr), 32'h41 + 32'(i));
      end
      quiet();
      tick();
      chk("drain_idle", 32'(idle), 32'd1);
      chk("drain_orphan", 32'(err_orphan), 32'd0);
      chk("drain_tag_full", 32'(tag_full), 32'd0);

      // Orphan result, then clear
      valid = 1'b1;
      tick();
      quiet();
      chk("orph_flag", 32'(err_orphan), 32'd1);
      chk("orph_wr_en", 32'(wr_en), 32'd0);
      tick();
      chk("orph_sticky", 32'(err_orphan), 32'd1);
      clear = 1'b1;
      tick();
      quiet();
      chk("clr_orphan", 32'(err_orphan), 32'd0);
      chk("clr_ovf", 32'(err_ovf), 32'd0);
      chk("clr_idle", 32'(idle), 32'd1);
      chk("clr_wr_addr", 32'(wr_addr), 32'd0);

      // Result in the same cycle as the push to an empty FIFO
      iss(8'h50, 8'h00, PE_MODE_NTT);
      valid = 1'b1;
      tick();
      quiet();
      chk("nobyp_orphan", 32'(err_orphan), 32'd1);
      chk("nobyp_wr_en", 32'(wr_en), 32'd0);
      chk("nobyp_idle", 32'(idle), 32'd0);
      valid = 1'b1; u2 = 12'h005; v2 = 12'h006;
      tick();
      quiet();
      chk("nobyp_late_en", 32'(wr_en), 32'd1);
      chk("nobyp_late_addr", 32'(wr_addr), 32'h50);
      chk("nobyp_late_data", 32'(wr_data), 32'h006005);

      // Orphan on the m port
      clear = 1'b1;
      tick();
      quiet();
      valid_m = 1'b1;
      tick();
      quiet();
      chk("morph_flag", 32'(err_orphan), 32'd1);
      chk("morph_wr_m_en", 32'(wr_m_en), 32'd0);
      clear = 1'b1;
      tick();
      quiet();

      // Async reset with tags in flight
      for (int i = 0; i < 6; i++) begin
         iss(8'h70 + 8'(i), 8'h90 + 8'(i), PE_MODE_CWM);
         if (i == 5) begin
            valid = 1'b1;
            u2 = 12'h777;
            v2 = 12'h888;
         end
         tick();
      end
      quiet();
      chk("pre_rst_wr_en", 32'(wr_en), 32'd1);
      chk("pre_rst_idle", 32'(idle), 32'd0);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_wr_en", 32'(wr_en), 32'd0);
      chk("arst_wr_m_en", 32'(wr_m_en), 32'd0);
      chk("arst_idle", 32'(idle), 32'd1);
      chk("arst_tag_full", 32'(tag_full), 32'd0);
      tick();
      rst = 1'b0;
      iss(8'h60, 8'h00, PE_MODE_NTT);
      tick();
      quiet();
      valid = 1'b1; u2 = 12'h001; v2 = 12'h002;
      tick();
      quiet();
      chk("fresh_wr_en", 32'(wr_en), 32'd1);
      chk("fresh_wr_addr", 32'(wr_addr), 32'h60);
      chk("fresh_wr_data", 32'(wr_data), 32'h002001);
      chk("fresh_orphan", 32'(err_orphan), 32'd0);
      tick();
      chk("fresh_idle", 32'(idle), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
